fpu_seq: RTL

- Multi-cycle, handshaked IEEE-754 floating-point unit for the chaos key-generation datapath.
- Supersedes the combinational add/sub/mul blocks with one shared, parametrised unit.
- Adds round-to-nearest-even, special-value handling and exception flags.
- Holds one operation in flight; the map iterator drives it through valid/ready.

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fpu_lzc.sv | 18 +
 rtl/fpu_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared encodings and width-derived constants for the sequential floating-point unit.
// No logic, so no latency or backpressure of its own.
package fpu_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_EXEC, S_MUL, S_NORM, S_ROUND, S_DONE
    } state_t;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    function automatic int bias_of(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Positive infinity: exponent all ones, fraction zero.
    function automatic logic [63:0] inf_of(input int ew, input int mw);
        return ((64'd1 << ew) - 64'd1) << mw;
    endfunction

    function automatic logic [63:0] qnan_of(input int ew, input int mw);
        return inf_of(ew, mw) | (64'd1 << (mw - 1));
    endfunction

    localparam int BIAS = bias_of(EXP_W_DEF);

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter over a W-bit word; all-zero input returns W.
// Purely combinational, no backpressure.
module fpu_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W) + 1
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_seq.sv
// Sequential IEEE-754 add/sub/mul with RNE rounding; one op in flight, 5 (add), MAN_W+4 (mul) or 1 (special) edges.
// in_ready only in IDLE; result/flags held in DONE until out_ready.
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int XW = EXP_W + 2;
    localparam int FW = MAN_W + 4;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int LW = $clog2(FW) + 1;
    localparam int CW = $clog2(MAN_W + 1);
    localparam logic [W-1:0] INF  = W'(inf_of(EXP_W, MAN_W));
    localparam logic [W-1:0] QNAN = W'(qnan_of(EXP_W, MAN_W));
    localparam logic signed [XW-1:0] BIAS_X = XW'(bias_of(EXP_W));
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);

    state_t state, state_nxt;

    logic [1:0]            op_q;
    logic [W-1:0]          a_q, b_q, result_q;
    logic [3:0]            flags_q;
    logic                  sign_q, sub_q, zero_q;
    logic [MAN_W:0]        ma_q, mb_q;
    logic [EXP_W-1:0]      diff_q;
    logic signed [XW-1:0]  exp_q;
    logic [FW-1:0]         fa_q, fb_q, nrm_q;
    logic [FW:0]           sum_q;
    logic [PW-1:0]         acc_q;
    logic [CW-1:0]         cnt_q;

    // Operand decode on the registered inputs
    logic [EXP_W-1:0] ea_r, eb_r, hi_exp, lo_exp;
    logic [MAN_W-1:0] fa_r, fb_r, hi_frac, lo_frac;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
    logic is_sub, is_mul, sa_r, sb_eff, swap;
    logic signed [XW-1:0] ea_x, eb_x;
    logic [W-1:0] spec_res;
    logic [3:0]   spec_flg;

    assign ea_r   = a_q[W-2:MAN_W];
    assign eb_r   = b_q[W-2:MAN_W];
    assign fa_r   = a_q[MAN_W-1:0];
    assign fb_r   = b_q[MAN_W-1:0];
    assign a_nan  = (&ea_r) & (|fa_r);
    assign b_nan  = (&eb_r) & (|fb_r);
    assign a_inf  = (&ea_r) & ~(|fa_r);
    assign b_inf  = (&eb_r) & ~(|fb_r);
    assign a_zero = ~(|ea_r);
    assign b_zero = ~(|eb_r);
    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    assign is_sub = (op_q == OP_SUB);
    assign is_mul = (op_q == OP_MUL);
    assign sa_r   = a_q[W-1];
    assign sb_eff = b_q[W-1] ^ is_sub;
    assign swap   = ~is_mul & (b_q[W-2:0] > a_q[W-2:0]);
    assign hi_exp  = swap ? eb_r : ea_r;
    assign lo_exp  = swap ? ea_r : eb_r;
    assign hi_frac = swap ? fb_r : fa_r;
    assign lo_frac = swap ? fa_r : fb_r;
    assign ea_x   = {2'b00, ea_r};
    assign eb_x   = {2'b00, eb_r};

    always_comb begin
        spec_res = '0;
        spec_flg = '0;
        if (a_nan | b_nan) begin
            spec_res = QNAN;
        end else if (is_mul) begin
            if ((a_inf & b_zero) | (b_inf & a_zero)) begin
                spec_res = QNAN;
                spec_flg[FLG_INV] = 1'b1;
            end else if (a_inf | b_inf) begin
                spec_res = {sa_r ^ b_q[W-1], INF[W-2:0]};
            end else begin
                spec_res = {sa_r ^ b_q[W-1], {(W-1){1'b0}}};
            end
        end else if (a_inf & b_inf) begin
            if (sa_r != sb_eff) begin
                spec_res = QNAN;
                spec_flg[FLG_INV] = 1'b1;
            end else begin
                spec_res = {sa_r, INF[W-2:0]};
            end
        end else if (a_inf) begin
            spec_res = {sa_r, INF[W-2:0]};
        end else if (b_inf) begin
            spec_res = {sb_eff, INF[W-2:0]};
        end else if (a_zero & b_zero) begin
            spec_res = {sa_r & sb_eff, {(W-1){1'b0}}};
        end else if (b_zero) begin
            spec_res = a_q;
        end else begin
            spec_res = {sb_eff, b_q[W-2:0]};
        end
    end

    // Alignment: smaller significand shifted into {mant, guard, round, sticky}
    logic [FW-1:0] al_ext, al_mask, al_fb;
    always_comb begin
        al_ext  = {mb_q, 3'b000};
        al_mask = ~({FW{1'b1}} << diff_q);
        al_fb   = FW'(1'b1);
        if (diff_q < EXP_W'(MAN_W + 3))
            al_fb = (al_ext >> diff_q) | FW'(|(al_ext & al_mask));
    end

    logic [PW-1:0] acc_nxt;
    logic [FW:0]   mul_fold;
    assign acc_nxt  = acc_q + (mb_q[cnt_q] ? (PW'(ma_q) << cnt_q) : '0);
    assign mul_fold = {acc_nxt[PW-1:PW-FW], acc_nxt[PW-FW-1] | (|acc_nxt[PW-FW-2:0])};

    logic [LW-1:0]        lz;
    logic [FW-1:0]        nrm_d;
    logic signed [XW-1:0] nexp_d;
    fpu_lzc #(.W(FW), .CW(LW)) u_lzc (.din(sum_q[FW-1:0]), .cnt(lz));
    assign nrm_d  = sum_q[FW] ? {sum_q[FW:2], sum_q[1] | sum_q[0]} : (sum_q[FW-1:0] << lz);
    assign nexp_d = sum_q[FW] ? exp_q + XW'(1) : exp_q - XW'(lz);

    logic [MAN_W:0]       rm;
    logic [MAN_W+1:0]     mr;
    logic [MAN_W-1:0]     frac_r;
    logic signed [XW-1:0] er;
    logic                 rnd_up, inx;
    logic [W-1:0]         rnd_res;
    logic [3:0]           rnd_flg;
    assign rm     = nrm_q[FW-1:3];
    assign rnd_up = nrm_q[2] & (nrm_q[1] | nrm_q[0] | rm[0]);
    assign inx    = |nrm_q[2:0];
    assign mr     = {1'b0, rm} + (MAN_W+2)'(rnd_up);
    assign er     = exp_q + XW'(mr[MAN_W+1]);
    assign frac_r = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];

    always_comb begin
        rnd_res = '0;
        rnd_flg = '0;
        if (!zero_q) begin
            if (er >= EMAX_X) begin
                rnd_res = {sign_q, INF[W-2:0]};
                rnd_flg[FLG_OVF] = 1'b1;
                rnd_flg[FLG_INX] = 1'b1;
            end else if (exp_q <= 0) begin
                rnd_res = {sign_q, {(W-1){1'b0}}};
                rnd_flg[FLG_UNF] = 1'b1;
                rnd_flg[FLG_INX] = 1'b1;
            end else begin
                rnd_res = {sign_q, er[EXP_W-1:0], frac_r};
                rnd_flg[FLG_INX] = inx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = S_UNPACK;
            S_UNPACK: state_nxt = special ? S_DONE : (is_mul ? S_MUL : S_ALIGN);
            S_ALIGN:  state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_NORM;
            S_MUL:    if (cnt_q == CW'(MAN_W)) state_nxt = S_NORM;
            S_NORM:   state_nxt = S_ROUND;
            S_ROUND:  state_nxt = S_DONE;
            S_DONE:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            cnt_q    <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op_q <= op;
                    a_q  <= a;
                    b_q  <= b;
                end
                S_UNPACK: if (special) begin
                    result_q <= spec_res;
                    flags_q  <= spec_flg;
                end else begin
                    sign_q <= is_mul ? (sa_r ^ b_q[W-1]) : (swap ? sb_eff : sa_r);
                    sub_q  <= sa_r ^ sb_eff;
                    ma_q   <= {1'b1, hi_frac};
                    mb_q   <= {1'b1, lo_frac};
                    diff_q <= hi_exp - lo_exp;
                    exp_q  <= is_mul ? (ea_x + eb_x - BIAS_X) : {2'b00, hi_exp};
                    acc_q  <= '0;
                    cnt_q  <= '0;
                end
                S_ALIGN: begin
                    fa_q <= {ma_q, 3'b000};
                    fb_q <= al_fb;
                end
                S_EXEC: sum_q <= sub_q ? ({1'b0, fa_q} - {1'b0, fb_q}) : ({1'b0, fa_q} + {1'b0, fb_q});
                S_MUL: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(MAN_W)) sum_q <= mul_fold;
                end
                S_NORM: begin
                    nrm_q  <= nrm_d;
                    exp_q  <= nexp_d;
                    zero_q <= ~(|sum_q);
                end
                S_ROUND: begin
                    result_q <= rnd_res;
                    flags_q  <= rnd_flg;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
